pipeline_scheduler: RTL and testbench

Central stall/flush sequencer for the 5-stage RV pipeline. It merges the ID data-hazard request, branch-in-ID, taken-branch-in-EX and a multi-cycle data-memory handshake into per-stage register load enables and bubble/flush controls. It sits beside the ID-stage hazard detector and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers plus the data-memory request. It also tracks memory timeout and counts stall cycles.

---
 rtl/pipeline_scheduler_pkg.sv | 45 ++++
 rtl/pipeline_scheduler_sat_counter.sv | 24 ++
 rtl/pipeline_scheduler.sv | 140 ++++++++++++++
 tb/tb_pipeline_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_scheduler_pkg.sv
// Shared pipeline definitions: scheduler state encoding, stage-control bundle, RV opcodes.
// No logic; constants and a helper for building stage-control words.
// Backpressure: n/a.
package pipeline_scheduler_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic if_id_flush;
    logic id_ex_load;
    logic id_ex_bubble;
    logic ex_mem_load;
    logic mem_wb_load;
    logic mem_req;
  } stage_ctrl_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // Every stage register gets the same enable; no flush or bubble.
  function automatic stage_ctrl_t ctrl_uniform(input logic load, input logic req);
    stage_ctrl_t c;
    c.pc_load      = load;
    c.if_id_load   = load;
    c.if_id_flush  = 1'b0;
    c.id_ex_load   = load;
    c.id_ex_bubble = 1'b0;
    c.ex_mem_load  = load;
    c.mem_wb_load  = load;
    c.mem_req      = req;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Latency: count updates one cycle after enable/clear.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_scheduler.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory, branch and hazard events.
// Latency: control outputs are combinational from state and inputs; counters update next cycle.
// Backpressure: a pending data-memory access freezes every stage until ack or timeout.
module pipeline_scheduler
  import pipeline_scheduler_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hazard_stall,
  input  logic             branch_id,
  input  logic             branch_taken_ex,
  input  logic             mem_access,
  input  logic             mem_ack,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic             id_ex_load,
  output logic             id_ex_bubble,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             mem_req,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int FC_W   = ($clog2(FLUSH_CYCLES + 1) > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [FC_W-1:0]   FLUSH_INIT = FC_W'(FLUSH_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

  sched_state_e    state, state_nxt;
  sched_state_e    ret_state, ret_state_nxt;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
  logic            mem_error_nxt;
  logic            wait_clr, wait_en;
  logic [WAIT_W-1:0] wait_cnt;
  stage_ctrl_t     ctrl;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      ret_state <= RUN;
      flush_cnt <= '0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_state_nxt;
      flush_cnt <= flush_cnt_nxt;
      mem_error <= mem_error_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ret_state_nxt = ret_state;
    flush_cnt_nxt = flush_cnt;
    mem_error_nxt = mem_error;
    wait_clr      = 1'b0;
    wait_en       = 1'b0;
    ctrl          = ctrl_uniform(1'b1, mem_access);

    case (state)
      MEM_WAIT: begin
        ctrl    = ctrl_uniform(1'b0, 1'b1);
        wait_en = 1'b1;
        // A timeout releases the pipeline exactly like an ack, but latches the error.
        if (mem_ack || (wait_cnt == WAIT_LAST)) begin
          ctrl      = ctrl_uniform(1'b1, 1'b1);
          state_nxt = ret_state;
          if (!mem_ack) begin
            mem_error_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (mem_access && !mem_ack) begin
          ctrl          = ctrl_uniform(1'b0, 1'b1);
          ret_state_nxt = (state == FLUSH) ? FLUSH : RUN;
          wait_clr      = 1'b1;
          state_nxt     = MEM_WAIT;
        end else if (state == FLUSH) begin
          // ID and EX already hold NOPs, so branch and hazard inputs are ignored here.
          ctrl.if_id_flush = 1'b1;
          flush_cnt_nxt    = flush_cnt - FC_W'(1);
          if (flush_cnt <= FC_W'(1)) begin
            state_nxt = RUN;
          end
        end else if (branch_taken_ex) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          if (FLUSH_CYCLES > 0) begin
            flush_cnt_nxt = FLUSH_INIT;
            state_nxt     = FLUSH;
          end
        end else if (hazard_stall) begin
          ctrl.pc_load      = 1'b0;
          ctrl.if_id_load   = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
        end else if (branch_id) begin
          ctrl.pc_load     = 1'b0;
          ctrl.if_id_flush = 1'b1;
        end
      end
    endcase

    if (!reset) begin
      ctrl = '0;
    end
  end

  assign pc_load      = ctrl.pc_load;
  assign if_id_load   = ctrl.if_id_load;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_load   = ctrl.id_ex_load;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_mem_load  = ctrl.ex_mem_load;
  assign mem_wb_load  = ctrl.mem_wb_load;
  assign mem_req      = ctrl.mem_req;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (1'b0),
    .enable (reset && !ctrl.pc_load),
    .count  (stall_count)
  );

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (wait_clr),
    .enable (wait_en),
    .count  (wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_scheduler.sv
// Scoreboard bench for pipeline_scheduler: directed scenarios followed by randomized traffic,
// expected per-cycle controls come from a cycle-level behavioural model of the stall rules.
module tb_pipeline_scheduler;

  localparam int FC   = 2;
  localparam int TO   = 15;
  localparam int CW   = 6;
  localparam int SMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          hazard_stall = 1'b0;
  logic          branch_id = 1'b0;
  logic          branch_taken_ex = 1'b0;
  logic          mem_access = 1'b0;
  logic          mem_ack = 1'b0;
  logic          pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_bubble;
  logic          ex_mem_load, mem_wb_load, mem_req, mem_error;
  logic [CW-1:0] stall_count;

  always #5 clock = ~clock;

  pipeline_scheduler #(
    .FLUSH_CYCLES (FC),
    .MEM_TIMEOUT  (TO),
    .CNT_W        (CW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .hazard_stall    (hazard_stall),
    .branch_id       (branch_id),
    .branch_taken_ex (branch_taken_ex),
    .mem_access      (mem_access),
    .mem_ack         (mem_ack),
    .pc_load         (pc_load),
    .if_id_load      (if_id_load),
    .if_id_flush     (if_id_flush),
    .id_ex_load      (id_ex_load),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_load     (ex_mem_load),
    .mem_wb_load     (mem_wb_load),
    .mem_req         (mem_req),
    .mem_error       (mem_error),
    .stall_count     (stall_count)
  );

  typedef struct {
    logic [7:0] ctrl;
    int         stall;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Model state: cycles spent waiting on memory, remaining bubble cycles, sticky error, stall tally.
  bit m_wait;
  int m_wait_n;
  int m_flush_left;
  int m_stall;
  bit m_err;

  task automatic step(input int r, input int hz, input int bid, input int bt,
                      input int ma, input int mk);
    exp_t e;
    bit   pc, ifl, ifx, idb, rest, req;
    @(posedge clock);
    #1;
    reset           = (r != 0);
    hazard_stall    = (hz != 0);
    branch_id       = (bid != 0);
    branch_taken_ex = (bt != 0);
    mem_access      = (ma != 0);
    mem_ack         = (mk != 0);
    cyc++;
    e.cyc = cyc;
    if (r == 0) begin
      m_wait = 0; m_wait_n = 0; m_flush_left = 0; m_stall = 0; m_err = 0;
      e.ctrl = 8'h00; e.stall = 0; e.err = 1'b0;
    end else begin
      e.stall = m_stall;
      e.err   = m_err;
      pc = 1; ifl = 1; ifx = 0; idb = 0; rest = 1; req = (ma != 0);
      if (m_wait) begin
        req = 1;
        if (mk != 0 || m_wait_n == TO - 1) begin
          if (mk == 0) m_err = 1;
          m_wait = 0;
        end else begin
          pc = 0; ifl = 0; rest = 0;
          m_wait_n++;
        end
      end else if (ma != 0 && mk == 0) begin
        pc = 0; ifl = 0; rest = 0; req = 1;
        m_wait = 1; m_wait_n = 0;
      end else if (m_flush_left > 0) begin
        ifx = 1;
        m_flush_left--;
      end else if (bt != 0) begin
        ifx = 1; idb = 1;
        m_flush_left = FC;
      end else if (hz != 0) begin
        pc = 0; ifl = 0; idb = 1;
      end else if (bid != 0) begin
        pc = 0; ifx = 1;
      end
      if (!pc && m_stall < SMAX) m_stall++;
      e.ctrl = {pc, ifl, ifx, rest, idb, rest, rest, req};
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clock) begin
    exp_t       e;
    logic [7:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_bubble,
             ex_mem_load, mem_wb_load, mem_req};
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl cyc=%0d got=%b exp=%b (pc,ifid_ld,ifid_fl,idex_ld,bub,exmem,memwb,req)",
                 e.cyc, act, e.ctrl);
      end
      checks++;
      if (stall_count !== CW'(e.stall)) begin
        errors++;
        $display("FAIL stall_count cyc=%0d got=%0d exp=%0d", e.cyc, stall_count, e.stall);
      end
      checks++;
      if (mem_error !== e.err) begin
        errors++;
        $display("FAIL mem_error cyc=%0d got=%b exp=%b", e.cyc, mem_error, e.err);
      end
    end
  end

  initial begin
    int ack_pct;
    int r, ma;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    idle(2);
    // data hazard for two cycles
    repeat (2) step(1, 1, 0, 0, 0, 0);
    idle(1);
    // taken branch with bubble cycles
    step(1, 0, 0, 1, 0, 0);
    idle(4);
    // memory access acked on its fourth cycle
    repeat (3) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    idle(2);
    // memory timeout, error stays sticky
    repeat (16) step(1, 0, 0, 0, 1, 0);
    idle(11);
    step(0, 0, 0, 0, 0, 0);
    idle(2);
    // stall beginning in the first bubble cycle
    step(1, 0, 0, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    idle(4);
    // stall beginning in the second bubble cycle
    step(1, 0, 0, 1, 0, 0);
    idle(1);
    repeat (3) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    idle(3);
    // reset pulse aborts a stall taken during a flush
    step(1, 0, 0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    // priority mixes and zero-wait accesses
    repeat (2) step(1, 0, 1, 0, 0, 0);
    repeat (2) step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 1);
    step(1, 1, 0, 1, 1, 1);
    idle(3);
    // stall_count saturation
    repeat (70) step(1, 1, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0);
    // randomized traffic with alternating memory latency regimes
    ack_pct = 40;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) ack_pct = ($urandom_range(0, 1) == 0) ? 5 : 40;
      r  = ($urandom_range(0, 299) != 0) ? 1 : 0;
      ma = ($urandom_range(0, 99) < 30) ? 1 : 0;
      step(r,
           ($urandom_range(0, 99) < 20) ? 1 : 0,
           ($urandom_range(0, 99) < 15) ? 1 : 0,
           ($urandom_range(0, 99) < 10) ? 1 : 0,
           ma,
           ($urandom_range(0, 99) < ack_pct) ? 1 : 0);
    end
    idle(1);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
